// File: rtl/axi4_ctrl.sv
// AXI4 frame-buffer master: packs a narrow write stream into 16-beat 256-bit INCR write bursts
// and fetches the frame back with 16-beat read bursts that are unpacked into a narrow read stream.
module axi4_ctrl #(
    parameter int unsigned C_W_WIDTH   = 32,
    parameter int unsigned C_R_WIDTH   = 32,
    parameter logic [29:0] C_WBASE     = 30'h0,
    parameter logic [29:0] C_RBASE     = 30'h0,
    parameter int unsigned C_BUF_BYTES = 4194304
) (
    input  logic                 axi_clk,
    input  logic                 axi_reset_n,
    output logic [3:0]           axi_awid,
    output logic [29:0]          axi_awaddr,
    output logic [3:0]           axi_awlen,
    output logic [2:0]           axi_awsize,
    output logic [1:0]           axi_awburst,
    output logic                 axi_awlock,
    output logic [3:0]           axi_awcache,
    output logic [2:0]           axi_awprot,
    output logic [3:0]           axi_awqos,
    output logic                 axi_awvalid,
    input  logic                 axi_awready,
    output logic [255:0]         axi_wdata,
    output logic [31:0]          axi_wstrb,
    output logic                 axi_wlast,
    output logic                 axi_wvalid,
    input  logic                 axi_wready,
    input  logic [3:0]           axi_bid,
    input  logic [1:0]           axi_bresp,
    input  logic                 axi_bvalid,
    output logic                 axi_bready,
    output logic [3:0]           axi_arid,
    output logic [29:0]          axi_araddr,
    output logic [3:0]           axi_arlen,
    output logic [2:0]           axi_arsize,
    output logic [1:0]           axi_arburst,
    output logic                 axi_arlock,
    output logic [3:0]           axi_arcache,
    output logic [2:0]           axi_arprot,
    output logic [3:0]           axi_arqos,
    output logic                 axi_arvalid,
    input  logic                 axi_arready,
    input  logic [3:0]           axi_rid,
    input  logic [255:0]         axi_rdata,
    input  logic [1:0]           axi_rresp,
    input  logic                 axi_rlast,
    input  logic                 axi_rvalid,
    output logic                 axi_rready,
    input  logic                 wframe_vsync,
    input  logic                 wframe_data_en,
    input  logic [C_W_WIDTH-1:0] wframe_data,
    input  logic                 rframe_vsync,
    input  logic                 rframe_data_en,
    output logic [C_R_WIDTH-1:0] rframe_data
);
    localparam int unsigned W_LANES = 256 / C_W_WIDTH;
    localparam int unsigned R_LANES = 256 / C_R_WIDTH;
    localparam int unsigned W_LW    = $clog2(W_LANES);
    localparam int unsigned R_LW    = $clog2(R_LANES);
    localparam int unsigned DEPTH   = 32;
    localparam int unsigned PW      = 5;
    localparam int unsigned CW      = 6;
    localparam int unsigned BURST   = 16;
    localparam logic [29:0] BURST_BYTES = 30'd512;
    localparam logic [29:0] W_END = C_WBASE + 30'(C_BUF_BYTES);
    localparam logic [29:0] R_END = C_RBASE + 30'(C_BUF_BYTES);

    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

    assign axi_awid = 4'd0;    assign axi_awlen = 4'd15;     assign axi_awsize = 3'b101;
    assign axi_awburst = 2'b01; assign axi_awlock = 1'b0;   assign axi_awcache = 4'b0011;
    assign axi_awprot = 3'd0;  assign axi_awqos = 4'd0;      assign axi_wstrb = '1;
    assign axi_arid = 4'd0;    assign axi_arlen = 4'd15;     assign axi_arsize = 3'b101;
    assign axi_arburst = 2'b01; assign axi_arlock = 1'b0;   assign axi_arcache = 4'b0011;
    assign axi_arprot = 3'd0;  assign axi_arqos = 4'd0;

    logic unused_in;
    assign unused_in = ^{axi_bid, axi_bresp, axi_rid, axi_rresp};

    // ---------------- write side ----------------
    w_state_t         w_state, w_nxt;
    logic [3:0]       wbeat, wbeat_nxt;
    logic             wvs_q, wvs_rise, wclr_pend, wclr_apply;
    logic [W_LW-1:0]  wlane, wlane_eff;
    logic [255:0]     pack, pack_nxt;
    logic [255:0]     wf_mem [DEPTH];
    logic [PW-1:0]    wf_wr, wf_rd, wf_wr_base, wf_rd_nxt;
    logic [CW-1:0]    wf_count;
    logic             wf_push, wf_pop, pack_last;
    logic [29:0]      w_step, waddr_inc;

    // A clear requested mid-burst waits until the FSM is back in IDLE.
    always_comb begin
        wvs_rise   = wframe_vsync & ~wvs_q;
        wclr_apply = (wclr_pend | wvs_rise) & (w_state == W_IDLE);
        wlane_eff  = wvs_rise ? '0 : wlane;
        pack_last  = (wlane_eff == W_LW'(W_LANES - 1));
        pack_nxt   = pack;
        pack_nxt[int'(wlane_eff) * C_W_WIDTH +: C_W_WIDTH] = wframe_data;
        wf_push    = wframe_data_en & pack_last & (wclr_apply | (wf_count != CW'(DEPTH)));
        wf_pop     = axi_wvalid & axi_wready;
        wf_wr_base = wclr_apply ? '0 : wf_wr;
        wf_rd_nxt  = wclr_apply ? '0 : wf_rd + PW'(wf_pop);
        w_step     = axi_awaddr + BURST_BYTES;
        waddr_inc  = (w_step == W_END) ? C_WBASE : w_step;
    end

    always_comb begin
        w_nxt     = w_state;
        wbeat_nxt = wbeat;
        case (w_state)
            W_IDLE: if (!wclr_apply && wf_count >= CW'(BURST)) w_nxt = W_AW;
            W_AW: if (axi_awready) begin
                w_nxt     = W_DATA;
                wbeat_nxt = '0;
            end
            W_DATA: if (axi_wready) begin
                wbeat_nxt = wbeat + 4'd1;
                if (wbeat == 4'd15) w_nxt = W_RESP;
            end
            W_RESP: if (axi_bvalid) w_nxt = W_IDLE;
            default: w_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (!axi_reset_n) begin
            w_state     <= W_IDLE;
            wbeat       <= '0;
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b0;
            axi_wlast   <= 1'b0;
            axi_bready  <= 1'b0;
            axi_awaddr  <= C_WBASE;
            wclr_pend   <= 1'b0;
            wvs_q       <= 1'b0;
        end else begin
            w_state     <= w_nxt;
            wbeat       <= wbeat_nxt;
            axi_awvalid <= (w_nxt == W_AW);
            axi_wvalid  <= (w_nxt == W_DATA);
            axi_wlast   <= (w_nxt == W_DATA) && (wbeat_nxt == 4'd15);
            axi_bready  <= (w_nxt == W_RESP);
            wvs_q       <= wframe_vsync;
            wclr_pend   <= (wclr_pend | wvs_rise) & ~wclr_apply;
            if (wclr_apply) axi_awaddr <= C_WBASE;
            else if (w_state == W_RESP && axi_bvalid) axi_awaddr <= waddr_inc;
        end
    end

    // Packer and write FIFO; wdata is prefetched from the next head each cycle.
    always_ff @(posedge axi_clk) begin
        if (!axi_reset_n) begin
            wlane     <= '0;
            pack      <= '0;
            wf_wr     <= '0;
            wf_rd     <= '0;
            wf_count  <= '0;
            axi_wdata <= '0;
        end else begin
            if (wframe_data_en) begin
                pack  <= pack_nxt;
                wlane <= pack_last ? '0 : wlane_eff + W_LW'(1);
            end else if (wvs_rise) begin
                wlane <= '0;
            end
            wf_wr     <= wf_wr_base + PW'(wf_push);
            wf_rd     <= wf_rd_nxt;
            wf_count  <= wclr_apply ? CW'(wf_push) : wf_count + CW'(wf_push) - CW'(wf_pop);
            axi_wdata <= wf_mem[wf_rd_nxt];
        end
    end

    always_ff @(posedge axi_clk) begin
        if (wf_push) wf_mem[wf_wr_base] <= pack_nxt;
    end

    // ---------------- read side ----------------
    r_state_t         r_state, r_nxt;
    logic             rvs_q, rvs_rise, rclr_pend, r_drain, r_beat, r_done;
    logic [255:0]     rf_mem [DEPTH];
    logic [PW-1:0]    rf_wr, rf_rd;
    logic [CW-1:0]    rf_count;
    logic             rf_push, rf_pop, rf_empty, up_last;
    logic [R_LW-1:0]  rlane;
    logic [255:0]     rf_head;
    logic [C_R_WIDTH-1:0] r_slice;
    logic [29:0]      r_step, raddr_inc;

    // Beats of a burst in flight during a read-frame restart are discarded.
    always_comb begin
        rvs_rise  = rframe_vsync & ~rvs_q;
        r_drain   = rclr_pend | rvs_rise;
        r_beat    = (r_state == R_DATA) & axi_rvalid;
        r_done    = r_beat & axi_rlast;
        rf_push   = r_beat & ~r_drain & (rf_count != CW'(DEPTH));
        rf_empty  = (rf_count == '0);
        up_last   = (rlane == R_LW'(R_LANES - 1));
        rf_pop    = rframe_data_en & ~rf_empty & up_last & ~rvs_rise;
        rf_head   = rf_mem[rf_rd];
        r_slice   = rf_head[int'(rlane) * C_R_WIDTH +: C_R_WIDTH];
        r_step    = axi_araddr + BURST_BYTES;
        raddr_inc = (r_step == R_END) ? C_RBASE : r_step;
    end

    always_comb begin
        r_nxt = r_state;
        case (r_state)
            R_IDLE: if (rframe_vsync && !r_drain && rf_count <= CW'(DEPTH - BURST)) r_nxt = R_ADDR;
            R_ADDR: if (axi_arready) r_nxt = R_DATA;
            R_DATA: if (axi_rvalid && axi_rlast) r_nxt = R_IDLE;
            default: r_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (!axi_reset_n) begin
            r_state     <= R_IDLE;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b0;
            axi_araddr  <= C_RBASE;
            rclr_pend   <= 1'b0;
            rvs_q       <= 1'b0;
        end else begin
            r_state     <= r_nxt;
            axi_arvalid <= (r_nxt == R_ADDR);
            axi_rready  <= (r_nxt == R_DATA);
            rvs_q       <= rframe_vsync;
            rclr_pend   <= r_done ? 1'b0 : (rclr_pend | (rvs_rise & (r_state != R_IDLE)));
            if (r_done) axi_araddr <= r_drain ? C_RBASE : raddr_inc;
            else if (rvs_rise && r_state == R_IDLE) axi_araddr <= C_RBASE;
        end
    end

    // Read FIFO and unpacker.
    always_ff @(posedge axi_clk) begin
        if (!axi_reset_n) begin
            rf_wr       <= '0;
            rf_rd       <= '0;
            rf_count    <= '0;
            rlane       <= '0;
            rframe_data <= '0;
        end else begin
            if (rvs_rise) begin
                rf_wr    <= '0;
                rf_rd    <= '0;
                rf_count <= '0;
                rlane    <= '0;
            end else begin
                rf_wr    <= rf_wr + PW'(rf_push);
                rf_rd    <= rf_rd + PW'(rf_pop);
                rf_count <= rf_count + CW'(rf_push) - CW'(rf_pop);
                if (rframe_data_en && !rf_empty) rlane <= up_last ? '0 : rlane + R_LW'(1);
            end
            if (rframe_data_en) rframe_data <= (rvs_rise | rf_empty) ? '0 : r_slice;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (rf_push) rf_mem[rf_wr] <= axi_rdata;
    end
endmodule

// File: tb/tb_axi4_ctrl.sv
// Scoreboard bench for axi4_ctrl: stimulus queues expected AW/W/AR/rframe traffic, a negedge monitor checks it.
module tb_axi4_ctrl;
    logic axi_clk = 1'b0;
    logic axi_reset_n;
    logic [3:0] axi_awid, axi_awlen, axi_awcache, axi_awqos, axi_arid, axi_arlen, axi_arcache, axi_arqos;
    logic [29:0] axi_awaddr, axi_araddr;
    logic [2:0] axi_awsize, axi_awprot, axi_arsize, axi_arprot;
    logic [1:0] axi_awburst, axi_arburst;
    logic axi_awlock, axi_arlock, axi_awvalid, axi_wlast, axi_wvalid, axi_bready, axi_arvalid, axi_rready;
    logic axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rlast, axi_rvalid;
    logic [255:0] axi_wdata, axi_rdata;
    logic [31:0] axi_wstrb;
    logic [3:0] axi_bid, axi_rid;
    logic [1:0] axi_bresp, axi_rresp;
    logic wframe_vsync, wframe_data_en, rframe_vsync, rframe_data_en;
    logic [31:0] wframe_data;
    logic [7:0] rframe_data;

    axi4_ctrl #(.C_W_WIDTH(32), .C_R_WIDTH(8), .C_WBASE(30'h0), .C_RBASE(30'h0), .C_BUF_BYTES(1024)) dut (
        .axi_clk(axi_clk), .axi_reset_n(axi_reset_n),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst), .axi_awlock(axi_awlock), .axi_awcache(axi_awcache), .axi_awprot(axi_awprot),
        .axi_awqos(axi_awqos), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready), .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready), .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(axi_arlock), .axi_arcache(axi_arcache),
        .axi_arprot(axi_arprot), .axi_arqos(axi_arqos), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .wframe_vsync(wframe_vsync), .wframe_data_en(wframe_data_en), .wframe_data(wframe_data),
        .rframe_vsync(rframe_vsync), .rframe_data_en(rframe_data_en), .rframe_data(rframe_data)
    );

    always #5 axi_clk = ~axi_clk;

    typedef struct packed { logic [255:0] d; logic last; } wbeat_t;
    logic [29:0] exp_aw [$];
    logic [29:0] exp_ar [$];
    wbeat_t      exp_w  [$];
    logic [7:0]  exp_r  [$];

    int pass_cnt = 0;
    int total_cnt = 0;
    logic mon_en = 1'b0;
    logic aw_hold = 1'b0, ar_hold = 1'b0, rd_pend = 1'b0;
    logic [29:0] aw_prev = '0, ar_prev = '0;
    logic [7:0] last_r = '0;
    int aw_acc = 0, w_done = 0;
    localparam logic [24:0] FIELDS = {4'd0, 4'd15, 3'd5, 2'd1, 1'd0, 4'd3, 3'd0, 4'd0};

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic fail_evt(input string nm);
        total_cnt++;
        $display("FAIL %s: event got 1 expected 0", nm);
    endtask

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    // Monitor: checks every handshake and output against the queued expectations.
    always @(negedge axi_clk) begin
        if (mon_en) begin
            if (axi_wvalid) chk("w_after_aw", 256'(aw_acc > w_done), 256'(1));
            if (aw_hold) chk("aw_stable", 256'({axi_awvalid, axi_awaddr}), 256'({1'b1, aw_prev}));
            if (ar_hold) chk("ar_stable", 256'({axi_arvalid, axi_araddr}), 256'({1'b1, ar_prev}));
            aw_hold = axi_awvalid & ~axi_awready;
            ar_hold = axi_arvalid & ~axi_arready;
            aw_prev = axi_awaddr;
            ar_prev = axi_araddr;
            if (axi_awvalid && axi_awready) begin
                aw_acc++;
                if (exp_aw.size() == 0) fail_evt("aw_unexpected");
                else begin
                    chk("awaddr", 256'(axi_awaddr), 256'(exp_aw.pop_front()));
                    chk("aw_fields", 256'({axi_awid, axi_awlen, axi_awsize, axi_awburst, axi_awlock,
                                           axi_awcache, axi_awprot, axi_awqos}), 256'(FIELDS));
                end
            end
            if (axi_wvalid && axi_wready) begin
                if (exp_w.size() == 0) fail_evt("w_unexpected");
                else begin
                    wbeat_t e;
                    e = exp_w.pop_front();
                    chk("wdata", axi_wdata, e.d);
                    chk("wlast", 256'(axi_wlast), 256'(e.last));
                    chk("wstrb", 256'(axi_wstrb), 256'(32'hFFFF_FFFF));
                end
                if (axi_wlast) w_done++;
            end
            if (axi_arvalid && axi_arready) begin
                if (exp_ar.size() == 0) fail_evt("ar_unexpected");
                else begin
                    chk("araddr", 256'(axi_araddr), 256'(exp_ar.pop_front()));
                    chk("ar_fields", 256'({axi_arid, axi_arlen, axi_arsize, axi_arburst, axi_arlock,
                                           axi_arcache, axi_arprot, axi_arqos}), 256'(FIELDS));
                end
            end
            if (rd_pend) begin
                if (exp_r.size() == 0) fail_evt("rframe_unexpected");
                else begin
                    last_r = exp_r.pop_front();
                    chk("rframe_data", 256'(rframe_data), 256'(last_r));
                end
            end else begin
                chk("rframe_hold", 256'(rframe_data), 256'(last_r));
            end
            rd_pend = rframe_data_en;
        end
    end

    // Streams n words starting at value base; optionally queues the resulting burst.
    task automatic send_words(input int base, input int n, input bit expect_burst, input logic [29:0] addr);
        logic [255:0] acc;
        wbeat_t b;
        acc = '0;
        if (expect_burst) exp_aw.push_back(addr);
        for (int i = 0; i < n; i++) begin
            wframe_data_en = 1'b1;
            wframe_data    = 32'(base + i);
            acc[(i % 8) * 32 +: 32] = 32'(base + i);
            if (expect_burst && (i % 8) == 7) begin
                b.d = acc;
                b.last = ((i / 8) == 15);
                exp_w.push_back(b);
            end
            tick();
        end
        wframe_data_en = 1'b0;
    endtask

    task automatic serve_read();
        int t;
        t = 0;
        while (!axi_arvalid && t < 200) begin tick(); t++; end
        if (!axi_arvalid) begin fail_evt("arvalid_timeout"); return; end
        repeat (4) tick();
        axi_arready = 1'b1;
        tick();
        axi_arready = 1'b0;
        for (int n = 0; n < 16; n++) begin
            t = 0;
            while (!axi_rready && t < 50) begin tick(); t++; end
            if (!axi_rready) begin fail_evt("rready_timeout"); return; end
            axi_rvalid = 1'b1;
            axi_rlast  = (n == 15);
            for (int i = 0; i < 8; i++) axi_rdata[i * 32 +: 32] = 32'(8 * n + i);
            if (n == 15) rframe_vsync = 1'b0;
            tick();
        end
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
    endtask

    task automatic request(input logic [7:0] e);
        rframe_data_en = 1'b1;
        exp_r.push_back(e);
        tick();
        rframe_data_en = 1'b0;
    endtask

    task automatic consume(input int nbytes);
        for (int k = 0; k < nbytes; k++) begin
            request(((k % 32) % 4 == 0) ? 8'(8 * (k / 32) + (k % 32) / 4) : 8'd0);
            if (k % 7 == 6) tick();
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_aw.size() + exp_w.size() + exp_ar.size() + exp_r.size()) != 0 && t < 2000) begin
            tick();
            t++;
        end
        if ((exp_aw.size() + exp_w.size() + exp_ar.size() + exp_r.size()) != 0) fail_evt("drain_timeout");
        repeat (20) tick();
    endtask

    initial begin
        int t;
        axi_reset_n = 1'b0;
        axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bid = '0; axi_bresp = '0;
        axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rdata = '0; axi_rid = '0; axi_rresp = '0;
        wframe_vsync = 1'b0; wframe_data_en = 1'b0; wframe_data = '0;
        rframe_vsync = 1'b0; rframe_data_en = 1'b0;
        repeat (10) tick();
        chk("reset_ctrl", 256'({axi_awvalid, axi_wvalid, axi_wlast, axi_bready, axi_arvalid, axi_rready}), 256'(0));
        chk("reset_rframe", 256'(rframe_data), 256'(0));
        chk("reset_addr", 256'({axi_awaddr, axi_araddr}), 256'(0));
        axi_reset_n = 1'b1;
        mon_en = 1'b1;
        repeat (20) tick();

        // Empty read FIFO yields zero.
        request(8'd0);
        request(8'd0);

        // Three bursts in one write frame: 0x0, 0x200, then wrap to 0x0 with a stalled AW.
        axi_awready = 1'b1; axi_wready = 1'b1; axi_bvalid = 1'b1;
        wframe_vsync = 1'b1;
        tick();
        send_words(0, 128, 1'b1, 30'h0);
        send_words(128, 128, 1'b1, 30'h200);
        axi_awready = 1'b0;
        send_words(256, 128, 1'b1, 30'h0);
        t = 0;
        while (!axi_awvalid && t < 200) begin tick(); t++; end
        if (!axi_awvalid) fail_evt("awvalid_timeout");
        repeat (5) tick();
        axi_awready = 1'b1;
        drain();

        // Partial frame is discarded; the next frame restarts at the base address.
        wframe_vsync = 1'b0; tick();
        wframe_vsync = 1'b1; tick();
        send_words(1000, 100, 1'b0, 30'h0);
        repeat (20) tick();
        wframe_vsync = 1'b0; tick();
        wframe_vsync = 1'b1; tick();
        send_words(2000, 128, 1'b1, 30'h0);
        drain();

        // Read burst at 0x0, partially unpacked.
        exp_ar.push_back(30'h0);
        rframe_vsync = 1'b1;
        serve_read();
        consume(9);
        drain();

        // New read frame: FIFO cleared, address back to base, full unpack.
        exp_ar.push_back(30'h0);
        rframe_vsync = 1'b1;
        tick();
        request(8'd0);
        request(8'd0);
        serve_read();
        consume(512);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
